// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk cycles.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter after the synchronizer.
module pwm_capture #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILTER_LEN  = 3
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             pwm_in,
  input  logic [CNT_W-1:0] max_period,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] high_meas,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic [CNT_W-1:0]       cnt_p_q, cnt_p_d;
  logic [CNT_W-1:0]       cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0]       high_lat_q, high_lat_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   stuck_q, stuck_d;
  logic                   stuck_level_q, stuck_level_d;
  logic                   busy_q, busy_d;

  logic                   raw_in;
  logic                   s_in;
  logic                   rise;
  logic                   fall;
  logic                   timeout;
  logic [CNT_W-1:0]       cnt_p_inc;
  logic [CNT_W-1:0]       cnt_h_inc;

  assign raw_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // s_in follows raw_in only once the current and previous FILTER_LEN-1 samples agree.
  localparam int unsigned HIST_W = FILTER_LEN - 1;

  logic [HIST_W-1:0] hist_q, hist_d;
  logic              s_filt_q, s_filt_d;

  always_comb begin
    hist_d   = (hist_q << 1) | HIST_W'(raw_in);
    s_filt_d = (hist_q == {HIST_W{raw_in}}) ? raw_in : s_filt_q;
  end

  assign s_in = s_filt_d;
`else
  assign s_in = raw_in;
`endif

  assign rise      = s_in & ~s_prev_q;
  assign fall      = ~s_in & s_prev_q;
  assign cnt_p_inc = (cnt_p_q == CNT_MAX) ? CNT_MAX : cnt_p_q + CNT_ONE;
  assign cnt_h_inc = (cnt_h_q == CNT_MAX) ? CNT_MAX : cnt_h_q + CNT_ONE;
  assign timeout   = (max_period != CNT_ZERO) && (cnt_p_q >= max_period);

  // Next-state and result logic; a timeout restarts cnt_p at 1 so stuck strobes repeat every max_period cycles.
  always_comb begin
    state_d       = state_q;
    s_prev_d      = s_in;
    cnt_p_d       = cnt_p_q;
    cnt_h_d       = cnt_h_q;
    high_lat_d    = high_lat_q;
    period_d      = period_q;
    high_d        = high_q;
    meas_valid_d  = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    if (!cap_en) begin
      state_d = IDLE;
      cnt_p_d = CNT_ZERO;
      cnt_h_d = CNT_ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_p_d = CNT_ZERO;
          cnt_h_d = CNT_ZERO;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_p_d = CNT_ONE;
            cnt_h_d = CNT_ONE;
            state_d = HIGH;
          end else if (timeout) begin
            period_d      = CNT_ZERO;
            high_d        = CNT_ZERO;
            stuck_d       = 1'b1;
            stuck_level_d = s_in;
            meas_valid_d  = 1'b1;
            cnt_p_d       = CNT_ONE;
            cnt_h_d       = CNT_ZERO;
          end else begin
            cnt_p_d = cnt_p_inc;
          end
        end
        HIGH: begin
          if (timeout && !rise) begin
            period_d      = CNT_ZERO;
            high_d        = CNT_ZERO;
            stuck_d       = 1'b1;
            stuck_level_d = s_in;
            meas_valid_d  = 1'b1;
            cnt_p_d       = CNT_ONE;
            cnt_h_d       = CNT_ZERO;
            state_d       = ARM;
          end else if (fall || rise) begin
            high_lat_d = cnt_h_q;
            cnt_p_d    = cnt_p_inc;
            state_d    = LOW;
          end else begin
            cnt_p_d = cnt_p_inc;
            cnt_h_d = cnt_h_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period_d     = cnt_p_q;
            high_d       = high_lat_q;
            stuck_d      = 1'b0;
            meas_valid_d = 1'b1;
            cnt_p_d      = CNT_ONE;
            cnt_h_d      = CNT_ONE;
            state_d      = HIGH;
          end else if (timeout) begin
            period_d      = CNT_ZERO;
            high_d        = CNT_ZERO;
            stuck_d       = 1'b1;
            stuck_level_d = s_in;
            meas_valid_d  = 1'b1;
            cnt_p_d       = CNT_ONE;
            cnt_h_d       = CNT_ZERO;
            state_d       = ARM;
          end else begin
            cnt_p_d = cnt_p_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      s_prev_q      <= 1'b0;
      cnt_p_q       <= CNT_ZERO;
      cnt_h_q       <= CNT_ZERO;
      high_lat_q    <= CNT_ZERO;
      period_q      <= CNT_ZERO;
      high_q        <= CNT_ZERO;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      hist_q        <= '0;
      s_filt_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      s_prev_q      <= s_prev_d;
      cnt_p_q       <= cnt_p_d;
      cnt_h_q       <= cnt_h_d;
      high_lat_q    <= high_lat_d;
      period_q      <= period_d;
      high_q        <= high_d;
      meas_valid_q  <= meas_valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
      busy_q        <= busy_d;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      hist_q        <= hist_d;
      s_filt_q      <= s_filt_d;
`endif
    end
  end

  assign period_meas = period_q;
  assign high_meas   = high_q;
  assign meas_valid  = meas_valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;
  assign busy        = busy_q;

endmodule
